// File: rtl/mem_arb_pkg.sv
// Shared encodings and default widths for the memory-port arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_WIDTH   = 32;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_STARVE_LIMIT = 4;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LD   = 2'd1,
        OWN_DM   = 2'd2,
        OWN_IF   = 2'd3
    } owner_t;

endpackage

// File: rtl/mem_arb_starve_counter.sv
// Counts consecutive denied fetch cycles in RUN and flags a forced fetch grant
// once the count reaches STARVE_LIMIT.
module mem_arb_starve_counter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic if_req,
    input  logic if_gnt,
    output logic force_if
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (!run || !if_req || if_gnt) begin
            count_next = '0;
        end else if (count_reg != CW'(STARVE_LIMIT)) begin
            count_next = count_reg + CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign force_if = (count_reg == CW'(STARVE_LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between loader, data stage and fetch, with BOOT/RUN sequencing
// and read-ownership tracking. Optional fetch starvation guard: MEM_PORT_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_done,
    input  logic                  ld_req,
    input  logic                  ld_wren,
    input  logic [0:ADDR_WIDTH-1] ld_address,
    input  logic [0:DATA_WIDTH-1] ld_data_in,
    output logic                  ld_gnt,
    input  logic                  dm_req,
    input  logic                  dm_wren,
    input  logic [0:ADDR_WIDTH-1] dm_address,
    input  logic [0:DATA_WIDTH-1] dm_data_in,
    output logic                  dm_gnt,
    output logic                  dm_rvalid,
    input  logic                  if_req,
    input  logic [0:ADDR_WIDTH-1] if_address,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic                  if_stall,
    output logic [0:DATA_WIDTH-1] rdata,
    output logic [0:ADDR_WIDTH-1] mem_address,
    output logic                  mem_wren,
    output logic [0:DATA_WIDTH-1] mem_data_in,
    input  logic [0:DATA_WIDTH-1] mem_data_out,
    output logic                  booting
);

    arb_state_t state_reg;
    arb_state_t state_next;
    owner_t     owner_reg;
    owner_t     owner_next;
    logic       force_if;

`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
    mem_arb_starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clock    (clock),
        .reset    (reset),
        .run      (state_reg == RUN),
        .if_req   (if_req),
        .if_gnt   (if_gnt),
        .force_if (force_if)
    );
`else
    // Without the guard fetch is never forced; a negative limit is meaningless anyway.
    assign force_if = (STARVE_LIMIT < 0);
`endif

    always_comb begin
        state_next = state_reg;
        if (state_reg == BOOT && load_done) begin
            state_next = RUN;
        end
    end

    always_comb begin
        ld_gnt = 1'b0;
        dm_gnt = 1'b0;
        if_gnt = 1'b0;
        if (state_reg == BOOT) begin
            ld_gnt = ld_req;
        end else begin
            dm_gnt = dm_req & ~force_if;
            if_gnt = if_req & (force_if | ~dm_req);
        end
    end

    // At most one grant is ever active, so the mux priority order is irrelevant.
    always_comb begin
        mem_address = '0;
        mem_wren    = 1'b0;
        mem_data_in = '0;
        owner_next  = OWN_NONE;
        if (ld_gnt) begin
            mem_address = ld_address;
            mem_wren    = ld_wren;
            mem_data_in = ld_data_in;
            if (!ld_wren) owner_next = OWN_LD;
        end else if (dm_gnt) begin
            mem_address = dm_address;
            mem_wren    = dm_wren;
            mem_data_in = dm_data_in;
            if (!dm_wren) owner_next = OWN_DM;
        end else if (if_gnt) begin
            mem_address = if_address;
            owner_next  = OWN_IF;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= BOOT;
            owner_reg <= OWN_NONE;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
        end
    end

    assign booting   = (state_reg == BOOT);
    assign if_stall  = booting | (if_req & ~if_gnt);
    assign dm_rvalid = (owner_reg == OWN_DM);
    assign if_rvalid = (owner_reg == OWN_IF);
    // Memory data is forced to zero unless a read of ours is returning this cycle.
    assign rdata     = (owner_reg != OWN_NONE) ? mem_data_out : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory model, rule-level reference model checked every
// cycle, plus directed vectors with literal expectations.
module tb_mem_port_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;
`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int W_NONE = 0;
    localparam int W_LD   = 1;
    localparam int W_DM   = 2;
    localparam int W_IF   = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          load_done = 1'b0;
    logic          ld_req = 1'b0, ld_wren = 1'b0;
    logic          dm_req = 1'b0, dm_wren = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] ld_address = '0, dm_address = '0, if_address = '0;
    logic [DW-1:0] ld_data_in = '0, dm_data_in = '0;
    logic          ld_gnt, dm_gnt, dm_rvalid, if_gnt, if_rvalid, if_stall, mem_wren, booting;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in, rdata;
    logic [DW-1:0] mem_data_out = '0;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clock(clock), .reset(reset), .load_done(load_done),
        .ld_req(ld_req), .ld_wren(ld_wren), .ld_address(ld_address),
        .ld_data_in(ld_data_in), .ld_gnt(ld_gnt),
        .dm_req(dm_req), .dm_wren(dm_wren), .dm_address(dm_address),
        .dm_data_in(dm_data_in), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
        .if_req(if_req), .if_address(if_address), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_stall(if_stall), .rdata(rdata),
        .mem_address(mem_address), .mem_wren(mem_wren), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .booting(booting)
    );

    // Synchronous single-port memory standing in for mem_controller (word index = addr[7:2]).
    logic [DW-1:0] mem [0:63];
    always @(posedge clock) begin
        if (mem_wren) mem[mem_address[7:2]] <= mem_data_in;
        mem_data_out <= mem[mem_address[7:2]];
    end

    // Reference model state: boot flag, denied-fetch run length, pending read return.
    bit            m_boot = 1'b1;
    int            m_starved = 0;
    int            m_pend_who = W_NONE;
    logic [DW-1:0] m_pend_data = '0;

    logic          e_ld_gnt, e_dm_gnt, e_if_gnt, e_wren, e_forced;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    int            e_read_who;

    always_comb begin
        e_forced   = GUARD && (m_starved >= LIMIT);
        e_ld_gnt   = m_boot && ld_req;
        e_dm_gnt   = !m_boot && dm_req && !e_forced;
        e_if_gnt   = !m_boot && if_req && (!dm_req || e_forced);
        e_wren     = 1'b0;
        e_addr     = '0;
        e_wdata    = '0;
        e_read_who = W_NONE;
        if (e_ld_gnt) begin
            e_addr = ld_address; e_wren = ld_wren; e_wdata = ld_data_in;
            e_read_who = ld_wren ? W_NONE : W_LD;
        end
        if (e_dm_gnt) begin
            e_addr = dm_address; e_wren = dm_wren; e_wdata = dm_data_in;
            e_read_who = dm_wren ? W_NONE : W_DM;
        end
        if (e_if_gnt) begin
            e_addr = if_address;
            e_read_who = W_IF;
        end
    end

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_boot      <= 1'b1;
            m_starved   <= 0;
            m_pend_who  <= W_NONE;
            m_pend_data <= '0;
        end else begin
            if (m_boot && load_done) m_boot <= 1'b0;
            if (!m_boot && if_req && !e_if_gnt) m_starved <= m_starved + 1;
            else m_starved <= 0;
            m_pend_who  <= e_read_who;
            m_pend_data <= mem[e_addr[7:2]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("m_ld_gnt", 32'(ld_gnt), 32'(e_ld_gnt));
        chk("m_dm_gnt", 32'(dm_gnt), 32'(e_dm_gnt));
        chk("m_if_gnt", 32'(if_gnt), 32'(e_if_gnt));
        chk("m_mem_address", mem_address, e_addr);
        chk("m_mem_wren", 32'(mem_wren), 32'(e_wren));
        chk("m_mem_data_in", mem_data_in, e_wdata);
        chk("m_booting", 32'(booting), 32'(m_boot));
        chk("m_if_stall", 32'(if_stall), 32'(m_boot || (if_req && !e_if_gnt)));
        chk("m_dm_rvalid", 32'(dm_rvalid), 32'(m_pend_who == W_DM));
        chk("m_if_rvalid", 32'(if_rvalid), 32'(m_pend_who == W_IF));
        chk("m_rdata", rdata, (m_pend_who != W_NONE) ? m_pend_data : '0);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    logic [31:0] la [3];
    logic [31:0] ldat [3];
    logic [31:0] fa [3];
    logic [31:0] fd [3];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        la[0] = 32'h80020004; ldat[0] = 32'hAFBF0004;
        la[1] = 32'h80020008; ldat[1] = 32'h8FA20000;
        la[2] = 32'h80020010; ldat[2] = 32'h12345678;
        fa[0] = 32'h80020000; fd[0] = 32'h27BDFFF8;
        fa[1] = 32'h80020004; fd[1] = 32'hAFBF0004;
        fa[2] = 32'h80020008; fd[2] = 32'h8FA20000;

        #1 reset = 1'b1;
        repeat (2) settle();
        chk("rst_booting", 32'(booting), 32'd1);
        chk("rst_if_stall", 32'(if_stall), 32'd1);
        chk("rst_gnts", {29'd0, ld_gnt, dm_gnt, if_gnt}, 32'd0);
        chk("rst_rvalid", {30'd0, dm_rvalid, if_rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_wren", 32'(mem_wren), 32'd0);

        // Boot write while fetch is already requesting
        step();
        reset = 1'b0;
        if_req = 1'b1; if_address = 32'h80020000;
        ld_req = 1'b1; ld_wren = 1'b1; ld_address = 32'h80020000; ld_data_in = 32'h27BDFFF8;
        settle();
        chk("boot_ld_gnt", 32'(ld_gnt), 32'd1);
        chk("boot_mem_wren", 32'(mem_wren), 32'd1);
        chk("boot_mem_address", mem_address, 32'h80020000);
        chk("boot_if_gnt", 32'(if_gnt), 32'd0);
        chk("boot_if_stall", 32'(if_stall), 32'd1);
        chk("boot_booting", 32'(booting), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            ld_address = la[i]; ld_data_in = ldat[i];
        end
        // Loader read: data returns only on rdata
        step();
        ld_wren = 1'b0; ld_address = 32'h80020004;
        step();
        ld_req = 1'b0;
        settle();
        chk("ld_read_rdata", rdata, 32'hAFBF0004);
        chk("ld_read_no_rvalid", {30'd0, dm_rvalid, if_rvalid}, 32'd0);

        // Boot exit with a simultaneous loader write
        step();
        load_done = 1'b1;
        ld_req = 1'b1; ld_wren = 1'b1; ld_address = 32'h80020014; ld_data_in = 32'hCAFEF00D;
        settle();
        chk("exit_ld_gnt", 32'(ld_gnt), 32'd1);
        chk("exit_booting_n", 32'(booting), 32'd1);
        step();
        load_done = 1'b0; ld_req = 1'b0; if_req = 1'b0;
        settle();
        chk("exit_booting_n1", 32'(booting), 32'd0);
        step();
        ld_req = 1'b1; ld_address = 32'h80020030; ld_data_in = 32'hDEADDEAD;
        settle();
        chk("run_ld_ignored", 32'(ld_gnt), 32'd0);
        chk("run_ld_no_write", 32'(mem_wren), 32'd0);
        step();
        ld_req = 1'b0; ld_wren = 1'b0;

        // Fetch streaming: three back-to-back reads
        for (int i = 0; i < 4; i++) begin
            step();
            if (i < 3) begin
                if_req = 1'b1; if_address = fa[i];
            end else begin
                if_req = 1'b0;
            end
            settle();
            if (i < 3) chk("stream_if_gnt", 32'(if_gnt), 32'd1);
            if (i > 0) begin
                chk("stream_if_rvalid", 32'(if_rvalid), 32'd1);
                chk("stream_rdata", rdata, fd[i-1]);
            end
        end

        // Contention: data stage wins, fetch follows once dm_req drops
        step();
        dm_req = 1'b1; dm_wren = 1'b0; dm_address = 32'h80020010;
        if_req = 1'b1; if_address = 32'h80020014;
        settle();
        chk("cont_dm_gnt", 32'(dm_gnt), 32'd1);
        chk("cont_if_stall", 32'(if_stall), 32'd1);
        chk("cont_if_gnt", 32'(if_gnt), 32'd0);
        step();
        dm_req = 1'b0;
        settle();
        chk("cont_dm_rvalid", 32'(dm_rvalid), 32'd1);
        chk("cont_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("cont_dm_rdata", rdata, 32'h12345678);
        chk("cont_if_gnt_late", 32'(if_gnt), 32'd1);
        step();
        if_req = 1'b0;
        settle();
        chk("cont_if_rvalid_late", 32'(if_rvalid), 32'd1);
        chk("cont_if_rdata", rdata, 32'hCAFEF00D);

        // Data-stage write then read back
        step();
        dm_req = 1'b1; dm_wren = 1'b1; dm_address = 32'h80020020; dm_data_in = 32'h0BADBEEF;
        step();
        dm_wren = 1'b0;
        step();
        dm_req = 1'b0;
        settle();
        chk("dm_rb_rvalid", 32'(dm_rvalid), 32'd1);
        chk("dm_rb_rdata", rdata, 32'h0BADBEEF);

        // Sustained contention: only the starve guard lets fetch through
        step();
        dm_req = 1'b1; dm_wren = 1'b0; dm_address = 32'h80020000;
        if_req = 1'b1; if_address = 32'h80020004;
        for (int c = 1; c <= 6; c++) begin
            settle();
            chk("starve_if_gnt", 32'(if_gnt), (GUARD && c == 5) ? 32'd1 : 32'd0);
            chk("starve_dm_gnt", 32'(dm_gnt), (GUARD && c == 5) ? 32'd0 : 32'd1);
            if (c < 6) step();
        end
        step();
        dm_req = 1'b0; if_req = 1'b0;

        // Reset right after a fetch grant: the read must never return
        step();
        if_req = 1'b1; if_address = 32'h80020008;
        settle();
        chk("mid_if_gnt", 32'(if_gnt), 32'd1);
        step();
        reset = 1'b1; if_req = 1'b0;
        settle();
        chk("mid_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("mid_booting", 32'(booting), 32'd1);
        step();
        reset = 1'b0;
        settle();
        chk("post_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("post_booting", 32'(booting), 32'd1);
        step();
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
